// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types, geometry and mode-register helper for the SDRAM controller
package sdram_pkg;

  // SDRAM command encodings as {ras_n, cas_n, we_n}
  typedef enum logic [2:0] {
    CMD_MRS   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_NOP   = 3'b111
  } cmd_e;

  // Controller states; every command state issues its command on its first clock
  // and then dwells with NOP until the relevant timing parameter has elapsed.
  typedef enum logic [3:0] {
    ST_RESET,
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF1,
    ST_INIT_REF2,
    ST_INIT_MRS,
    ST_IDLE,
    ST_REFRESH,
    ST_ACTIVATE,
    ST_RW
  } state_e;

  // Data bus direction seen from the controller
  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_e;

  localparam int BA_W   = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int ADDR_W = BA_W + ROW_W + COL_W;
  localparam int DATA_W = 16;

  // Core word address layout
  typedef struct packed {
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } addr_t;

  // Mode register: burst length 1, sequential, write burst = programmed length
  function automatic logic [ROW_W-1:0] mode_reg(input int unsigned cas_latency);
    logic [2:0] cl;
    cl = cas_latency[2:0];
    return {3'b000, 1'b0, 2'b00, cl, 1'b0, 3'b000};
  endfunction

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/dram_if.sv
// rtl/dram_if.sv - SDRAM pin bundle driven by the controller
interface dram_if;
  import sdram_pkg::*;

  logic              clk;
  logic              cke;
  logic              ras_n;
  logic              cas_n;
  logic              we_n;
  logic [ROW_W-1:0]  a;
  logic [BA_W-1:0]   ba;
  logic [1:0]        dqm;
  dir_e              dir;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;

  modport ctrl (
    output clk, cke, ras_n, cas_n, we_n, a, ba, dqm, dir, data_out,
    input  data_in
  );

  modport mem (
    input  clk, cke, ras_n, cas_n, we_n, a, ba, dqm, dir, data_out,
    output data_in
  );

endinterface

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - free-running refresh interval counter with sticky pending flag
module sdram_refresh_timer
#(
  parameter int REFRESH_INTERVAL = 750
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic pending
);

  localparam int CW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_INTERVAL - 1);

  logic [CW-1:0] r_count;
  logic          r_pending;
  logic          w_wrap;

  assign w_wrap  = (r_count == LAST);
  assign pending = r_pending;

  // Count continuously; a wrap sets pending and wins over a same-cycle clear,
  // a wrap while already pending simply leaves it set (no refresh backlog).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count <= w_wrap ? '0 : r_count + CW'(1);
      if (w_wrap) begin
        r_pending <= 1'b1;
      end else if (clear) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_ctrl.sv
// rtl/sdram_ctrl.sv - closed-page single-word SDRAM controller with init and auto-refresh
module sdram_ctrl
  import sdram_pkg::*;
#(
  parameter int T_INIT           = 10000,
  parameter int T_RP             = 2,
  parameter int T_RCD            = 2,
  parameter int T_RFC            = 7,
  parameter int T_WR             = 2,
  parameter int CAS_LATENCY      = 2,
  parameter int REFRESH_INTERVAL = 750
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  dram_if.ctrl              dram
);

  localparam int MRS_WAIT  = 2;
  localparam int RD_DWELL  = CAS_LATENCY + T_RP;
  localparam int WR_DWELL  = T_WR + T_RP;
  localparam int MAX_DWELL = max2(max2(T_INIT, T_RFC),
                                  max2(max2(RD_DWELL, WR_DWELL), max2(T_RCD, MRS_WAIT)));
  localparam int CNT_W     = $clog2(MAX_DWELL + 1);
  localparam logic [ROW_W-1:0] MODE_WORD = mode_reg(CAS_LATENCY);
  localparam logic [ROW_W-1:0] A10_ONLY  = ROW_W'(1) << 10;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_last_cnt;
  logic              w_last;
  logic              w_first;

  logic              w_ref_pending;
  logic              w_ref_clear;
  logic              w_accept;
  logic              w_rsp_capture;

  addr_t             r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_be;
  logic              r_init_done;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  cmd_e              w_cmd;
  logic [ROW_W-1:0]  w_a;
  logic [BA_W-1:0]   w_ba;
  logic [1:0]        w_dqm;
  dir_e              w_dir;
  logic              w_cke;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_ref_clear),
    .pending (w_ref_pending)
  );

  assign req_ready     = (r_state == ST_IDLE) && r_init_done && !w_ref_pending;
  assign w_accept      = req_valid && req_ready;
  assign w_ref_clear   = (r_state == ST_IDLE) && r_init_done && w_ref_pending;
  assign w_first       = (r_cnt == '0);
  assign w_last        = (r_cnt == w_last_cnt);
  assign w_rsp_capture = (r_state == ST_RW) && !r_write && (r_cnt == CNT_W'(CAS_LATENCY));

  // Last dwell count for each timed state (clocks in state minus one)
  always_comb begin
    w_last_cnt = '0;
    case (r_state)
      ST_INIT_WAIT: w_last_cnt = CNT_W'(T_INIT - 1);
      ST_INIT_PRE:  w_last_cnt = CNT_W'(T_RP - 1);
      ST_INIT_REF1: w_last_cnt = CNT_W'(T_RFC - 1);
      ST_INIT_REF2: w_last_cnt = CNT_W'(T_RFC - 1);
      ST_INIT_MRS:  w_last_cnt = CNT_W'(MRS_WAIT - 1);
      ST_REFRESH:   w_last_cnt = CNT_W'(T_RFC - 1);
      ST_ACTIVATE:  w_last_cnt = CNT_W'(T_RCD - 1);
      ST_RW:        w_last_cnt = r_write ? CNT_W'(WR_DWELL - 1) : CNT_W'(RD_DWELL - 1);
      default:      w_last_cnt = '0;
    endcase
  end

  // State register and in-state clock counter, restarted on every state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state selection; refresh beats a simultaneous request in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RESET:     w_state_nxt = ST_INIT_WAIT;
      ST_INIT_WAIT: if (w_last) w_state_nxt = ST_INIT_PRE;
      ST_INIT_PRE:  if (w_last) w_state_nxt = ST_INIT_REF1;
      ST_INIT_REF1: if (w_last) w_state_nxt = ST_INIT_REF2;
      ST_INIT_REF2: if (w_last) w_state_nxt = ST_INIT_MRS;
      ST_INIT_MRS:  if (w_last) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (w_ref_clear) begin
          w_state_nxt = ST_REFRESH;
        end else if (w_accept) begin
          w_state_nxt = ST_ACTIVATE;
        end
      end
      ST_REFRESH:   if (w_last) w_state_nxt = ST_IDLE;
      ST_ACTIVATE:  if (w_last) w_state_nxt = ST_RW;
      ST_RW:        if (w_last) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_RESET;
    endcase
  end

  // Pin values decoded from state; commands only on the first clock of a state
  always_comb begin
    w_cmd = CMD_NOP;
    w_a   = '0;
    w_ba  = '0;
    w_dqm = 2'b00;
    w_dir = DIR_IN;
    w_cke = 1'b1;
    case (r_state)
      ST_RESET: begin
        w_cke = 1'b0;
        w_dqm = 2'b11;
      end
      ST_INIT_PRE: begin
        if (w_first) begin
          w_cmd = CMD_PRE;
          w_a   = A10_ONLY;
        end
      end
      ST_INIT_REF1, ST_INIT_REF2, ST_REFRESH: begin
        if (w_first) w_cmd = CMD_REF;
      end
      ST_INIT_MRS: begin
        if (w_first) begin
          w_cmd = CMD_MRS;
          w_a   = MODE_WORD;
        end
      end
      ST_ACTIVATE: begin
        if (w_first) begin
          w_cmd = CMD_ACT;
          w_ba  = r_addr.ba;
          w_a   = r_addr.row;
        end
      end
      ST_RW: begin
        if (w_first) begin
          w_ba = r_addr.ba;
          w_a  = {2'b00, 1'b1, 1'b0, r_addr.col};
          if (r_write) begin
            w_cmd = CMD_WRITE;
            w_dir = DIR_OUT;
            w_dqm = ~r_be;
          end else begin
            w_cmd = CMD_READ;
          end
        end
      end
      default: begin
        w_cmd = CMD_NOP;
      end
    endcase
  end

  // Request capture, init completion flag and read-response register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_be        <= 2'b00;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= addr_t'(req_addr);
        r_write <= req_write;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      if ((r_state == ST_INIT_MRS) && w_last) begin
        r_init_done <= 1'b1;
      end
      r_rsp_valid <= w_rsp_capture;
      if (w_rsp_capture) begin
        r_rsp_rdata <= dram.data_in;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign init_done = r_init_done;

  assign dram.clk      = ~clk;
  assign dram.cke      = w_cke;
  assign dram.ras_n    = w_cmd[2];
  assign dram.cas_n    = w_cmd[1];
  assign dram.we_n     = w_cmd[0];
  assign dram.a        = w_a;
  assign dram.ba       = w_ba;
  assign dram.dqm      = w_dqm;
  assign dram.dir      = w_dir;
  assign dram.data_out = r_wdata;

endmodule
